mdu_issue_ctrl: RTL and testbench
=================================

MDU_ISSUE_CTRL -- requirements
Module: mdu_issue_ctrl

Interface
REQ-001 Parameter MULT_LAT, default 2: cycles from a MULT/MULTU/MTHI/MTLO issue until HI/LO is readable.
REQ-002 Parameter DIV_MIN, default 2: cycles after a DIV/DIVU issue during which md_accessible is ignored.
REQ-003 Parameter DIV_TIMEOUT, default 40: maximum cycles spent waiting for a divide.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ex_valid  in  1  EX stage holds an MDU-class instruction.
REQ-007 ex_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
REQ-008 ex_src0, ex_src1  in  32 each  rs and rt operand values.
REQ-009 flush  in  1  OR of the mem and wb clear/stop/jump signals.
REQ-010 md_op  out  6  one-hot issue pulse to the multiply/divide unit: bit0 mult, bit1 multu, bit2 div, bit3 divu, bit4 mthi, bit5 mtlo.
REQ-011 md_in0, md_in1  out  32 each  operands to the unit; MT data is on md_in0.
REQ-012 md_read_hi  out  1  selects HI (1) or LO (0) for md_res.
REQ-013 md_accessible  in  1  the unit reports HI/LO usable.
REQ-014 md_res  in  32  HI/LO read data from the unit.
REQ-015 ex_stall  out  1  holds the EX stage.
REQ-016 ex_res, ex_res_valid  out  32, 1  MFHI/MFLO result for GPR writeback.
REQ-017 md_timeout  out  1  sticky divide-timeout error flag.

Function
REQ-018 FSM states: IDLE, MUL_WAIT, DIV_WAIT, MT_WAIT; a 6-bit cycle counter cnt runs in every non-IDLE state.
REQ-019 In IDLE with ex_valid=1, flush=0, and ex_op 0..5: assert the matching md_op bit for exactly one cycle, drive md_in0=ex_src0 and md_in1=ex_src1, clear cnt to 0, and go to MUL_WAIT (ops 0,1), DIV_WAIT (ops 2,3), or MT_WAIT (ops 4,5).
REQ-020 ex_stall stays 0 on the issue cycle; the issuing instruction retires.
REQ-021 md_op SHALL be 0 in every cycle that is not an issue cycle.
REQ-022 md_in0 and md_in1 SHALL equal ex_src0 and ex_src1 combinationally in all cycles.
REQ-023 MUL_WAIT and MT_WAIT: cnt increments each cycle; the FSM returns to IDLE on the edge where cnt = MULT_LAT-1.
REQ-024 DIV_WAIT, cnt < DIV_MIN: increment cnt; ignore md_accessible.
REQ-025 DIV_WAIT, cnt >= DIV_MIN and md_accessible=1: go to IDLE.
REQ-026 DIV_WAIT, cnt = DIV_TIMEOUT-1 and md_accessible=0: go to IDLE and set md_timeout.
REQ-027 md_timeout clears only on reset.
REQ-028 MFHI/MFLO in IDLE with flush=0: no stall; md_read_hi = (ex_op==6); ex_res = md_res combinationally; ex_res_valid=1 in the same cycle.
REQ-029 md_read_hi SHALL be 1 whenever ex_op=6, and 0 otherwise.
REQ-030 ex_stall = ex_valid and not flush and state != IDLE; no md_op pulse and ex_res_valid=0 while stalled.
REQ-031 A stalled instruction SHALL be handled per REQ-019/REQ-028 in the first cycle the FSM is back in IDLE.
REQ-032 flush=1 in any state: the next state is IDLE and cnt clears to 0.
REQ-033 While flush=1: no md_op pulse, ex_res_valid=0, ex_stall=0.
REQ-034 flush=1 during DIV_WAIT does not set md_timeout.
REQ-035 ex_valid=0 in IDLE: all outputs are idle; md_read_hi still follows ex_op.

Reset
REQ-036 rst_n=0, asynchronously: FSM to IDLE, cnt=0, md_timeout=0.
REQ-037 While rst_n=0: md_op=0, ex_stall=0, ex_res_valid=0.
REQ-038 Reset asserted mid-divide SHALL abandon the wait; the first cycle after release is IDLE.

Verification
REQ-039 MULT src 0x00000003 / 0xFFFFFFFE, then MFLO next cycle -> md_op=6'b000001 for 1 cycle; MFLO stalls exactly 2 cycles; ex_res_valid with ex_res=md_res, md_read_hi=0.
REQ-040 DIVU 100/7 with md_accessible=1 in the first 2 cycles, then low 30 cycles, then high, plus MFHI waiting -> stall until md_accessible rises after cnt>=2; exit at cycle 33; md_read_hi=1.
REQ-041 DIV with md_accessible stuck 0 -> return to IDLE after 40 cycles; md_timeout=1 and stays 1 until reset.
REQ-042 MTHI 0xDEADBEEF, then flush in MT_WAIT cycle 0 with MFHI pending -> IDLE next cycle; no ex_res_valid during flush.
REQ-043 Back-to-back MULTU, MULTU -> second stalls 2 cycles, then issues md_op=6'b000010 exactly once.
REQ-044 rst_n low mid-DIV_WAIT, async with no clock edge -> ex_stall and md_op are 0 immediately; IDLE after release.

Source files
------------

// File: rtl/mdu_issue_ctrl.sv
// Issue/stall controller between the EX stage and the multiply/divide unit.
// Pulses one-hot ops to the unit, stalls EX while HI/LO is busy, forwards MFHI/MFLO data.
module mdu_issue_ctrl #(
    parameter int MULT_LAT    = 2,
    parameter int DIV_MIN     = 2,
    parameter int DIV_TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [2:0]  ex_op,
    input  logic [31:0] ex_src0,
    input  logic [31:0] ex_src1,
    input  logic        flush,
    output logic [5:0]  md_op,
    output logic [31:0] md_in0,
    output logic [31:0] md_in1,
    output logic        md_read_hi,
    input  logic        md_accessible,
    input  logic [31:0] md_res,
    output logic        ex_stall,
    output logic [31:0] ex_res,
    output logic        ex_res_valid,
    output logic        md_timeout
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        MT_WAIT  = 2'd3
    } state_t;

    localparam logic [5:0] MUL_LAST = 6'(MULT_LAT - 1);
    localparam logic [5:0] DIV_FLOOR = 6'(DIV_MIN);
    localparam logic [5:0] DIV_LAST = 6'(DIV_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [5:0] cnt, cnt_nxt;
    logic       timeout_hit;

    logic idle;
    logic live;
    logic mf_read;
    logic issue;

    assign idle    = (state == IDLE);
    assign live    = rst_n & ex_valid & ~flush;
    assign mf_read = ex_op[2] & ex_op[1];
    assign issue   = live & idle & ~mf_read;

    // Operand and result paths are pure pass-through; only the strobes are gated.
    assign md_in0       = ex_src0;
    assign md_in1       = ex_src1;
    assign md_read_hi   = (ex_op == 3'd6);
    assign ex_res       = md_res;
    assign ex_res_valid = live & idle & mf_read;
    assign ex_stall     = live & ~idle;

    always_comb begin
        md_op = '0;
        if (issue) begin
            case (ex_op)
                3'd0:    md_op = 6'b000001;
                3'd1:    md_op = 6'b000010;
                3'd2:    md_op = 6'b000100;
                3'd3:    md_op = 6'b001000;
                3'd4:    md_op = 6'b010000;
                3'd5:    md_op = 6'b100000;
                default: md_op = '0;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_hit = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (issue) begin
                        case (ex_op)
                            3'd0, 3'd1: state_nxt = MUL_WAIT;
                            3'd2, 3'd3: state_nxt = DIV_WAIT;
                            default:    state_nxt = MT_WAIT;
                        endcase
                    end
                end
                MUL_WAIT, MT_WAIT: begin
                    if (cnt == MUL_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end
                DIV_WAIT: begin
                    // md_accessible is untrustworthy for the first DIV_MIN cycles.
                    if (cnt < DIV_FLOOR) begin
                        cnt_nxt = cnt + 6'd1;
                    end else if (md_accessible) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == DIV_LAST) begin
                        state_nxt   = IDLE;
                        cnt_nxt     = '0;
                        timeout_hit = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            md_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (timeout_hit) begin
                md_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: multiply, divide, MT, flush, timeout and async reset.
module tb_mdu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [2:0]  ex_op;
    logic [31:0] ex_src0;
    logic [31:0] ex_src1;
    logic        flush;
    logic [5:0]  md_op;
    logic [31:0] md_in0;
    logic [31:0] md_in1;
    logic        md_read_hi;
    logic        md_accessible;
    logic [31:0] md_res;
    logic        ex_stall;
    logic [31:0] ex_res;
    logic        ex_res_valid;
    logic        md_timeout;

    int checks = 0;
    int errors = 0;

    mdu_issue_ctrl #(
        .MULT_LAT    (2),
        .DIV_MIN     (2),
        .DIV_TIMEOUT (40)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_op         (ex_op),
        .ex_src0       (ex_src0),
        .ex_src1       (ex_src1),
        .flush         (flush),
        .md_op         (md_op),
        .md_in0        (md_in0),
        .md_in1        (md_in1),
        .md_read_hi    (md_read_hi),
        .md_accessible (md_accessible),
        .md_res        (md_res),
        .ex_stall      (ex_stall),
        .ex_res        (ex_res),
        .ex_res_valid  (ex_res_valid),
        .md_timeout    (md_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b1; ex_op = 3'd0; flush = 1'b0;
        ex_src0 = '0; ex_src1 = '0; md_accessible = 1'b0; md_res = '0;
        settle();
        chk("rst_md_op", 32'(md_op), 32'h0);
        chk("rst_stall", 32'(ex_stall), 32'h0);
        chk("rst_timeout", 32'(md_timeout), 32'h0);
        ex_op = 3'd7;
        settle();
        chk("rst_res_valid", 32'(ex_res_valid), 32'h0);
        chk("rst_read_hi_lo", 32'(md_read_hi), 32'h0);
        tick();
        ex_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // MULT then MFLO
        ex_valid = 1'b1; ex_op = 3'd0; ex_src0 = 32'h00000003; ex_src1 = 32'hFFFFFFFE;
        settle();
        chk("mult_md_op", 32'(md_op), 32'h01);
        chk("mult_in0", md_in0, 32'h00000003);
        chk("mult_in1", md_in1, 32'hFFFFFFFE);
        chk("mult_stall", 32'(ex_stall), 32'h0);
        tick();
        ex_op = 3'd7; md_res = 32'hFFFFFFFA;
        settle();
        chk("mflo_stall1", 32'(ex_stall), 32'h1);
        chk("mflo_md_op1", 32'(md_op), 32'h0);
        chk("mflo_rv1", 32'(ex_res_valid), 32'h0);
        tick();
        chk("mflo_stall2", 32'(ex_stall), 32'h1);
        chk("mflo_in0_stalled", md_in0, 32'h00000003);
        tick();
        chk("mflo_stall3", 32'(ex_stall), 32'h0);
        chk("mflo_rv", 32'(ex_res_valid), 32'h1);
        chk("mflo_res", ex_res, 32'hFFFFFFFA);
        chk("mflo_read_hi", 32'(md_read_hi), 32'h0);
        chk("mflo_md_op", 32'(md_op), 32'h0);
        tick();

        // Idle outputs with ex_valid low; md_read_hi tracks ex_op
        ex_valid = 1'b0; ex_op = 3'd6;
        settle();
        chk("idle_read_hi", 32'(md_read_hi), 32'h1);
        chk("idle_rv", 32'(ex_res_valid), 32'h0);
        chk("idle_md_op", 32'(md_op), 32'h0);
        tick();

        // Back-to-back MULTU
        ex_valid = 1'b1; ex_op = 3'd1; ex_src0 = 32'h12345678; ex_src1 = 32'h9;
        settle();
        chk("multu1_md_op", 32'(md_op), 32'h02);
        tick();
        chk("multu2_stall1", 32'(ex_stall), 32'h1);
        chk("multu2_md_op1", 32'(md_op), 32'h0);
        tick();
        chk("multu2_stall2", 32'(ex_stall), 32'h1);
        chk("multu2_md_op2", 32'(md_op), 32'h0);
        tick();
        chk("multu2_stall3", 32'(ex_stall), 32'h0);
        chk("multu2_md_op3", 32'(md_op), 32'h02);
        tick();
        ex_valid = 1'b0;
        settle();
        chk("multu2_after_md_op", 32'(md_op), 32'h0);
        tick();
        tick();

        // DIVU 100/7 with MFHI waiting
        ex_valid = 1'b1; ex_op = 3'd3; ex_src0 = 32'd100; ex_src1 = 32'd7; md_accessible = 1'b1;
        settle();
        chk("divu_md_op", 32'(md_op), 32'h08);
        tick();
        ex_op = 3'd6; md_res = 32'd2;
        for (int i = 0; i < 33; i++) begin
            md_accessible = (i < 2) || (i == 32);
            settle();
            chk("divu_stall", 32'(ex_stall), 32'h1);
            tick();
        end
        chk("divu_exit_stall", 32'(ex_stall), 32'h0);
        chk("divu_rv", 32'(ex_res_valid), 32'h1);
        chk("divu_res", ex_res, 32'd2);
        chk("divu_read_hi", 32'(md_read_hi), 32'h1);
        chk("divu_timeout", 32'(md_timeout), 32'h0);
        tick();
        ex_valid = 1'b0; md_accessible = 1'b0;

        // MTHI then flush in MT_WAIT with MFHI pending
        ex_valid = 1'b1; ex_op = 3'd4; ex_src0 = 32'hDEADBEEF; ex_src1 = 32'h0;
        settle();
        chk("mthi_md_op", 32'(md_op), 32'h10);
        chk("mthi_in0", md_in0, 32'hDEADBEEF);
        tick();
        ex_op = 3'd6; flush = 1'b1; md_res = 32'hDEADBEEF;
        settle();
        chk("mthi_flush_stall", 32'(ex_stall), 32'h0);
        chk("mthi_flush_rv", 32'(ex_res_valid), 32'h0);
        chk("mthi_flush_md_op", 32'(md_op), 32'h0);
        tick();
        flush = 1'b0;
        settle();
        chk("mfhi_post_flush_stall", 32'(ex_stall), 32'h0);
        chk("mfhi_post_flush_rv", 32'(ex_res_valid), 32'h1);
        chk("mfhi_post_flush_res", ex_res, 32'hDEADBEEF);
        tick();

        // Flush blocks an issue in IDLE
        ex_op = 3'd2; flush = 1'b1;
        settle();
        chk("flush_idle_md_op", 32'(md_op), 32'h0);
        chk("flush_idle_stall", 32'(ex_stall), 32'h0);
        tick();
        flush = 1'b0; ex_valid = 1'b0;
        tick();

        // Flush on the last divide cycle must not raise the timeout
        ex_valid = 1'b1; ex_op = 3'd2; md_accessible = 1'b0;
        settle();
        chk("divf_md_op", 32'(md_op), 32'h04);
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 39; i++) tick();
        ex_valid = 1'b1; ex_op = 3'd7; flush = 1'b1;
        settle();
        chk("divf_flush_stall", 32'(ex_stall), 32'h0);
        tick();
        flush = 1'b0;
        settle();
        chk("divf_timeout", 32'(md_timeout), 32'h0);
        chk("divf_idle_rv", 32'(ex_res_valid), 32'h1);
        tick();
        ex_valid = 1'b0;

        // DIV timeout with MFLO waiting
        ex_valid = 1'b1; ex_op = 3'd2; ex_src0 = 32'hFFFFFF9C; ex_src1 = 32'd7;
        settle();
        chk("divt_md_op", 32'(md_op), 32'h04);
        tick();
        ex_op = 3'd7;
        for (int i = 0; i < 40; i++) begin
            settle();
            chk("divt_stall", 32'(ex_stall), 32'h1);
            chk("divt_timeout_low", 32'(md_timeout), 32'h0);
            tick();
        end
        chk("divt_exit_stall", 32'(ex_stall), 32'h0);
        chk("divt_rv", 32'(ex_res_valid), 32'h1);
        chk("divt_timeout_set", 32'(md_timeout), 32'h1);
        ex_valid = 1'b0;
        tick();
        tick();
        chk("divt_timeout_sticky", 32'(md_timeout), 32'h1);

        // Async reset mid divide
        ex_valid = 1'b1; ex_op = 3'd3;
        settle();
        chk("divr_md_op", 32'(md_op), 32'h08);
        tick();
        ex_op = 3'd6;
        settle();
        chk("divr_stall_before", 32'(ex_stall), 32'h1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("divr_async_stall", 32'(ex_stall), 32'h0);
        chk("divr_async_md_op", 32'(md_op), 32'h0);
        chk("divr_async_timeout", 32'(md_timeout), 32'h0);
        tick();
        rst_n = 1'b1;
        settle();
        chk("divr_release_stall", 32'(ex_stall), 32'h0);
        chk("divr_release_rv", 32'(ex_res_valid), 32'h1);
        tick();
        ex_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
